multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Sequencing controller for the multicycle ARM datapath (shared instr/data memory, single ALU).
//  Decodes instr[31:12] (cond, op, funct, rd) into per-state datapath controls.
//  Owns the NZCV flags register and the condition check. Gates all architectural writes.
//  Sits beside the datapath in the processor top. Replaces single-cycle control decode.
// PARAMETERS
//  none. Encodings are fixed by ctrl_pkg.
// PORTS
//  clk         in   1   system clock, rising edge
//  reset       in   1   asynchronous, active-high; returns FSM to FETCH
//  instr       in   20  instr[31:12] from IR: cond[31:28] op[27:26] funct[25:20] rd[15:12]
//  alu_flags   in   4   NZCV from ALU, current cycle
//  pcwrite     out  1   PC register enable
//  adrsrc      out  1   memory address: 0=PC, 1=result
//  memwrite    out  1   data memory write enable
//  irwrite     out  1   instruction register enable
//  regwrite    out  1   register file write enable
//  resultsrc   out  2   00=ALUOut, 01=Data, 10=ALUResult
//  alusrca     out  1   0=RD1(A), 1=PC
//  alusrcb     out  2   00=RD2, 01=ExtImm, 10=const 4
//  alucontrol  out  2   00=ADD 01=SUB 10=AND 11=ORR
//  immsrc      out  2   = op
//  regsrc      out  2   [0]=(op==10) select R15, [1]=(op==01) select rd as RA2
// BEHAVIOUR
//  - Moore FSM on clk. Outputs decode from state plus the instr fields.
//  - FETCH: adrsrc=0, alusrca=1, alusrcb=10, ADD, resultsrc=10, irwrite=1, pcwrite=1 -> DECODE.
//  - DECODE: alusrca=1, alusrcb=10, ADD, resultsrc=10. Latch cond_ok = cond_check(cond, flags_q).
//    Next state by op: 00 -> EXECR (funct[5]=0) or EXECI (funct[5]=1); 01 -> MEMADR; 10 -> BRANCH.
//    op=11 -> FETCH (undefined instruction, no side effects).
//  - MEMADR: alusrca=0, alusrcb=01, ADD. Next is MEMRD if funct[0]=1 (LDR), else MEMWR.
//  - MEMRD: adrsrc=1, resultsrc=00 -> MEMWB.
//  - MEMWB: resultsrc=01, regwrite=cond_ok -> FETCH.
//  - MEMWR: adrsrc=1, memwrite=cond_ok -> FETCH.
//  - EXECR / EXECI: alusrca=0, alusrcb=00 / 01. ALU op from funct[4:1]:
//    0100=ADD, 0010=SUB, 0000=AND, 1100=ORR. Other codes map to ADD.
//    flags_q <= alu_flags when funct[0]=1 (S bit) && cond_ok. Only N,Z update for AND/ORR;
//    C,V update only for ADD/SUB. -> ALUWB.
//  - ALUWB: resultsrc=00, regwrite=cond_ok -> FETCH. If rd==4'hF, also pcwrite=cond_ok.
//  - BRANCH: alusrca=0, alusrcb=01, ADD, resultsrc=10, pcwrite=cond_ok -> FETCH.
//  - Outputs not listed for a state are 0.
//  - Latency in cycles, FETCH inclusive: B=3, DP=4, STR=4, LDR=5. Undefined op=2.
//  - Conditions: all 15 ARM codes EQ..AL; cond 4'hF treated as AL.
//  - cond_ok is frozen from DECODE until FETCH, so a flag update in EXEC never affects the same
//    instruction's writeback.
//  - Reset (async, any state): state=FETCH, flags_q=0000, cond_ok=0.
//    While reset is high, pcwrite/irwrite/memwrite/regwrite are forced to 0.
//    The other outputs show FETCH values.
// STRUCTURE
//  - ctrl_pkg: state enum (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH).
//    Also holds the ALU-op, resultsrc/alusrcb encodings and cond-code localparams.
//  - Sub-module cond_check: combinational (cond[3:0], nzcv[3:0]) -> ok.
// TESTING
//  - ADD R1,R1,R2 (instr=20'hE0811): FETCH,DECODE,EXECR,ALUWB. regwrite=1 only in ALUWB.
//    alucontrol=00 in EXECR.
//  - LDR R2,[R0,#4] (20'hE5902): 5 states. adrsrc=1 in MEMRD. regwrite=1, resultsrc=01 in MEMWB.
//  - STR R2,[R0,#4] (20'hE5802): memwrite=1 only in MEMWR. regwrite never asserted.
//  - SUBS (20'hE0500) with alu_flags=4'b0100 in EXECR -> flags_q=0100.
//    Then BEQ (20'h0A000): pcwrite=1 in BRANCH. Then BNE (20'h1A000): pcwrite=0 in BRANCH.
//  - ADDEQ with flags_q=0000 (20'h00811): reaches ALUWB with regwrite=0.
//    ADD with rd=F (20'hE081F): pcwrite=1 in ALUWB.
//  - Reset asserted during MEMRD: state=FETCH and flags_q=0 immediately; no write enable high.
//    Op=11 (20'hEC000): DECODE->FETCH.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle ARM controller: states, mux selects, ALU ops, cond codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_e;

  localparam int unsigned INSTR_W = 20;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_ORR  = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE;

  // Map the data-processing cmd field to an ALU op; unknown commands fall back to ADD.
  function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
    case (cmd)
      4'b0100: alu_decode = ALU_ADD;
      4'b0010: alu_decode = ALU_SUB;
      4'b0000: alu_decode = ALU_AND;
      4'b1100: alu_decode = ALU_ORR;
      default: alu_decode = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluation against the NZCV flags.
module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       ok_o
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv_i;

  // Evaluate the condition; the never-code is treated as always.
  always_comb begin
    ok_o = 1'b1;
    case (cond_i)
      COND_EQ: ok_o = z;
      COND_NE: ok_o = ~z;
      COND_CS: ok_o = c;
      COND_CC: ok_o = ~c;
      COND_MI: ok_o = n;
      COND_PL: ok_o = ~n;
      COND_VS: ok_o = v;
      COND_VC: ok_o = ~v;
      COND_HI: ok_o = c & ~z;
      COND_LS: ok_o = ~c | z;
      COND_GE: ok_o = (n == v);
      COND_LT: ok_o = (n != v);
      COND_GT: ok_o = ~z & (n == v);
      COND_LE: ok_o = z | (n != v);
      default: ok_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM sequencing controller: Moore FSM, NZCV flags, condition gating of writes.
module multicycle_controller
  import ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic [3:0]         alu_flags,
  output logic               pcwrite,
  output logic               adrsrc,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regwrite,
  output logic [1:0]         resultsrc,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         alucontrol,
  output logic [1:0]         immsrc,
  output logic [1:0]         regsrc
);

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ok_q, cond_ok_d;
  logic       cond_ok_c;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [1:0] alu_op;
  logic       unused_rn;

  assign cond      = instr[19:16];
  assign op        = instr[15:14];
  assign funct     = instr[13:8];
  assign rd        = instr[3:0];
  assign alu_op    = alu_decode(funct[4:1]);
  assign unused_rn = ^instr[7:4];

  cond_check u_cond_check (
    .cond_i (cond),
    .nzcv_i (flags_q),
    .ok_o   (cond_ok_c)
  );

  // State, flags and frozen condition result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      flags_q   <= 4'b0000;
      cond_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      cond_ok_q <= cond_ok_d;
    end
  end

  // Next state, flag/condition updates and per-state datapath controls.
  always_comb begin
    state_d    = state_q;
    flags_d    = flags_q;
    cond_ok_d  = cond_ok_q;
    pcwrite    = 1'b0;
    adrsrc     = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    resultsrc  = RES_ALUOUT;
    alusrca    = 1'b0;
    alusrcb    = SRCB_RD2;
    alucontrol = ALU_ADD;
    immsrc     = op;
    regsrc     = {op == OP_MEM, op == OP_BR};

    case (state_q)
      FETCH: begin
        alusrca   = 1'b1;
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALURESULT;
        irwrite   = 1'b1;
        pcwrite   = 1'b1;
        state_d   = DECODE;
      end
      DECODE: begin
        alusrca   = 1'b1;
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALURESULT;
        cond_ok_d = cond_ok_c;
        case (op)
          OP_DP:   state_d = funct[5] ? EXECI : EXECR;
          OP_MEM:  state_d = MEMADR;
          OP_BR:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        alusrcb = SRCB_EXTIMM;
        state_d = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        adrsrc  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        resultsrc = RES_DATA;
        regwrite  = cond_ok_q;
        state_d   = FETCH;
      end
      MEMWR: begin
        adrsrc   = 1'b1;
        memwrite = cond_ok_q;
        state_d  = FETCH;
      end
      EXECR, EXECI: begin
        alusrcb    = (state_q == EXECI) ? SRCB_EXTIMM : SRCB_RD2;
        alucontrol = alu_op;
        if (funct[0] && cond_ok_q) begin
          flags_d[3:2] = alu_flags[3:2];
          // Logical ops leave carry and overflow untouched.
          if (alu_op == ALU_ADD || alu_op == ALU_SUB) flags_d[1:0] = alu_flags[1:0];
        end
        state_d = ALUWB;
      end
      ALUWB: begin
        regwrite = cond_ok_q;
        pcwrite  = cond_ok_q & (rd == 4'hF);
        state_d  = FETCH;
      end
      BRANCH: begin
        alusrcb   = SRCB_EXTIMM;
        resultsrc = RES_ALURESULT;
        pcwrite   = cond_ok_q;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // No architectural write can leak out while reset is held.
    if (reset) begin
      pcwrite  = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller with an instruction-level reference model.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] instr;
  logic [3:0]  alu_flags;
  logic        pcwrite, adrsrc, memwrite, irwrite, regwrite, alusrca;
  logic [1:0]  resultsrc, alusrcb, alucontrol, immsrc, regsrc;
  logic [15:0] obs;
  logic [15:0] want;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  model_flags;
  logic        model_ok;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .alu_flags  (alu_flags),
    .pcwrite    (pcwrite),
    .adrsrc     (adrsrc),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .resultsrc  (resultsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .alucontrol (alucontrol),
    .immsrc     (immsrc),
    .regsrc     (regsrc)
  );

  always #5 clk = ~clk;

  assign obs = {pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc, alusrca,
                alusrcb, alucontrol, immsrc, regsrc};

  // ARM condition semantics on {N,Z,C,V}.
  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [1:0] alu_of(input logic [3:0] cmd);
    case (cmd)
      4'b0010: return 2'b01;
      4'b0000: return 2'b10;
      4'b1100: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Cycle count of an instruction, FETCH included.
  function automatic int instr_len(input logic [19:0] ins);
    case (ins[15:14])
      2'b00:   return 4;
      2'b01:   return ins[8] ? 5 : 4;
      2'b10:   return 3;
      default: return 2;
    endcase
  endfunction

  // Expected control vector for cycle s of instruction ins, given its condition result.
  function automatic logic [15:0] exp_vec(input logic [19:0] ins, input int s, input logic ok);
    logic       pcw, adr, mw, irw, rw, asa;
    logic [1:0] rs, asb, ac, op;
    logic [5:0] f;
    op = ins[15:14];
    f  = ins[13:8];
    {pcw, adr, mw, irw, rw, asa} = 6'b0;
    rs = 2'b00; asb = 2'b00; ac = 2'b00;
    if (s == 0) begin
      asa = 1'b1; asb = 2'b10; rs = 2'b10; irw = 1'b1; pcw = 1'b1;
    end else if (s == 1) begin
      asa = 1'b1; asb = 2'b10; rs = 2'b10;
    end else if (op == 2'b00) begin
      if (s == 2) begin
        asb = f[5] ? 2'b01 : 2'b00;
        ac  = alu_of(f[4:1]);
      end else begin
        rw  = ok;
        pcw = ok && (ins[3:0] == 4'hF);
      end
    end else if (op == 2'b01) begin
      if (s == 2) asb = 2'b01;
      else if (s == 3) begin
        adr = 1'b1;
        mw  = ok && !f[0];
      end else begin
        rs = 2'b01;
        rw = ok;
      end
    end else begin
      asb = 2'b01; rs = 2'b10; pcw = ok;
    end
    return {pcw, adr, mw, irw, rw, rs, asa, asb, ac, op, op == 2'b01, op == 2'b10};
  endfunction

  // Flag effect of an executed data-processing step.
  task automatic model_exec(input logic [19:0] ins, input int s, input logic [3:0] af);
    logic [3:0] cmd;
    cmd = ins[12:9];
    if (ins[15:14] == 2'b00 && s == 2 && ins[8] && model_ok) begin
      if (cmd == 4'b0000 || cmd == 4'b1100) model_flags = {af[3:2], model_flags[1:0]};
      else model_flags = af;
    end
  endtask

  task automatic drive_step(input logic [19:0] ins, input int s, input logic [3:0] af);
    instr     = ins;
    alu_flags = af;
    if (s == 1) model_ok = cond_holds(ins[19:16], model_flags);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    instr = 20'hE0811;
    alu_flags = 4'hF;
    model_flags = 4'h0;
    model_ok = 1'b0;
    #2;
    checks++;
    if (obs !== 16'b0_0_0_0_0_10_1_10_00_00_00) begin
      errors++;
      $display("FAIL reset_outputs got %h want %h", obs, 16'b0_0_0_0_0_10_1_10_00_00_00);
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== 16'b0_0_0_0_0_10_1_10_00_00_00) begin
      errors++;
      $display("FAIL reset_held got %h want %h", obs, 16'b0_0_0_0_0_10_1_10_00_00_00);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed;
    logic [19:0] prog [9] = '{20'hE0811, 20'hE5902, 20'hE5802, 20'hE0500, 20'h0A000,
                              20'h1A000, 20'h00811, 20'hE081F, 20'hEC000};
    logic [3:0] af;
    foreach (prog[i]) begin
      for (int s = 0; s < instr_len(prog[i]); s++) begin
        af = (prog[i] == 20'hE0500 && s == 2) ? 4'b0100 : 4'(i * 3 + s);
        if (prog[i] == 20'h00811) model_flags = model_flags;
        drive_step(prog[i], s, af);
        want = exp_vec(prog[i], s, model_ok);
        checks++;
        if (obs !== want) begin
          errors++;
          $display("FAIL directed instr=%h step=%0d got %h want %h", prog[i], s, obs, want);
        end
        model_exec(prog[i], s, af);
        @(posedge clk); #1;
      end
      // Clear Z before the ADDEQ so it must be skipped.
      if (prog[i] == 20'h1A000) begin
        for (int s = 0; s < 4; s++) begin
          drive_step(20'hE0100, s, 4'b0000);
          want = exp_vec(20'hE0100, s, model_ok);
          checks++;
          if (obs !== want) begin
            errors++;
            $display("FAIL clear_flags step=%0d got %h want %h", s, obs, want);
          end
          model_exec(20'hE0100, s, 4'b0000);
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [19:0] prog [2] = '{20'hE0500, 20'hE5902};
    foreach (prog[i]) begin
      for (int s = 0; s < instr_len(prog[i]); s++) begin
        drive_step(prog[i], s, (s == 2) ? 4'b0100 : 4'b1011);
        want = exp_vec(prog[i], s, model_ok);
        checks++;
        if (obs !== want) begin
          errors++;
          $display("FAIL pre_reset instr=%h step=%0d got %h want %h", prog[i], s, obs, want);
        end
        model_exec(prog[i], s, (s == 2) ? 4'b0100 : 4'b1011);
        if (i == 1 && s == 3) break;
        @(posedge clk); #1;
      end
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (obs !== 16'b0_0_0_0_0_10_1_10_00_01_10) begin
      errors++;
      $display("FAIL reset_in_memrd got %h want %h", obs, 16'b0_0_0_0_0_10_1_10_00_01_10);
    end
    model_flags = 4'h0;
    @(posedge clk); #1;
    reset = 1'b0;
    // Z was cleared by reset, so BEQ must not write the PC.
    for (int s = 0; s < 3; s++) begin
      drive_step(20'h0A000, s, 4'b0100);
      want = exp_vec(20'h0A000, s, model_ok);
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL post_reset_beq step=%0d got %h want %h", s, obs, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random;
    logic [19:0] ins;
    logic [3:0]  af;
    logic [3:0]  cmds [4] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100};
    for (int n = 0; n < 80; n++) begin
      ins = 20'($urandom);
      ins[12:9] = cmds[$urandom_range(0, 3)];
      for (int s = 0; s < instr_len(ins); s++) begin
        af = 4'($urandom);
        drive_step(ins, s, af);
        want = exp_vec(ins, s, model_ok);
        checks++;
        if (obs !== want) begin
          errors++;
          $display("FAIL random n=%0d instr=%h step=%0d got %h want %h", n, ins, s, obs, want);
        end
        model_exec(ins, s, af);
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
